// File: rtl/unidade_de_busca_pkg.sv
// pacote_processador: instruction width, opcode field position, hlt opcode and fetch states shared by the processor blocks
package pacote_processador;
  localparam int LARGURA_INSTR = 32;
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 27;
  localparam logic [4:0] OPCODE_HLT = 5'd18;
  typedef enum logic [1:0] {ESPERA, BUSCA, PARADO} estado_t;
  function automatic logic eh_hlt(input logic [LARGURA_INSTR-1:0] w);
    return w[OPCODE_MSB:OPCODE_LSB] == OPCODE_HLT;
  endfunction
endpackage

// File: rtl/contador_de_programa.sv
// contador_de_programa: PC register; clk/rst, carregar_i loads destino_i, incrementar_i adds 1, pc_o is the current PC
module contador_de_programa #(
  parameter logic [31:0] ENDERECO_INICIAL = 32'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        carregar_i,
  input  logic        incrementar_i,
  input  logic [31:0] destino_i,
  output logic [31:0] pc_o
);
  logic [31:0] pc_q, pc_d;
  always_comb pc_d = carregar_i ? destino_i : incrementar_i ? pc_q + 32'd1 : pc_q;
  always_ff @(posedge clk) begin
    if (rst) pc_q <= ENDERECO_INICIAL;
    else pc_q <= pc_d;
  end
  assign pc_o = pc_q;
endmodule

// File: rtl/unidade_de_busca.sv
// unidade_de_busca: instruction fetch; endereco/instrucao memory side, ir/ir_valido/avancar/pc_atual decoder side, desvio/destino redirect, parado/erro status
module unidade_de_busca
  import pacote_processador::*;
#(
  parameter int unsigned ENDERECO_INICIAL = 1,
  parameter int unsigned TAM_MEMORIA = 21
) (
  input  logic                     clock,
  input  logic                     reset,
  output logic [31:0]              endereco,
  input  logic [LARGURA_INSTR-1:0] instrucao,
  output logic [LARGURA_INSTR-1:0] ir,
  output logic                     ir_valido,
  input  logic                     avancar,
  output logic [31:0]              pc_atual,
  input  logic                     desvio,
  input  logic [31:0]              destino,
  output logic                     parado,
  output logic                     erro
);
  estado_t estado_q, estado_d;
  logic [LARGURA_INSTR-1:0] ir_q, ir_d;
  logic [31:0] pc_atual_q, pc_atual_d, pc;
  logic valido_q, valido_d, erro_q, erro_d;
  logic carregar, busca, em_faixa, hlt, incrementar;
  contador_de_programa #(.ENDERECO_INICIAL(32'(ENDERECO_INICIAL))) u_pc (
    .clk(clock),
    .rst(reset),
    .carregar_i(carregar),
    .incrementar_i(incrementar),
    .destino_i(destino),
    .pc_o(pc)
  );
  always_comb begin
    carregar = desvio && estado_q != PARADO;
    busca = estado_q == BUSCA && !desvio && (!valido_q || avancar);
    em_faixa = pc <= 32'(TAM_MEMORIA - 1);
    hlt = eh_hlt(instrucao);
    incrementar = busca && em_faixa && !hlt;
    estado_d = estado_q == ESPERA ? BUSCA : estado_q;
    ir_d = ir_q;
    pc_atual_d = pc_atual_q;
    valido_d = valido_q && !avancar;
    erro_d = erro_q;
    if (carregar) valido_d = 1'b0;
    else if (busca && em_faixa) begin
      ir_d = instrucao;
      pc_atual_d = pc;
      valido_d = 1'b1;
      if (hlt) estado_d = PARADO;
    end else if (busca) begin
      valido_d = 1'b0;
      erro_d = 1'b1;
      estado_d = PARADO;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q <= ESPERA;
      ir_q <= '0;
      pc_atual_q <= '0;
      valido_q <= 1'b0;
      erro_q <= 1'b0;
    end else begin
      estado_q <= estado_d;
      ir_q <= ir_d;
      pc_atual_q <= pc_atual_d;
      valido_q <= valido_d;
      erro_q <= erro_d;
    end
  end
  assign endereco = pc;
  assign ir = ir_q;
  assign ir_valido = valido_q;
  assign pc_atual = pc_atual_q;
  assign parado = estado_q == PARADO;
  assign erro = erro_q;
endmodule

// File: tb/tb_unidade_de_busca.sv
// tb_unidade_de_busca: directed stimulus with a behavioural fetch model checked every cycle plus literal expectations
module tb_unidade_de_busca;
  localparam int TAM = 21;
  localparam logic [31:0] HLT_WORD = 32'h9000_0123;
  logic clock = 1'b0, reset = 1'b1, avancar = 1'b0, desvio = 1'b0;
  logic [31:0] destino = '0, endereco, instrucao, ir, pc_atual;
  logic ir_valido, parado, erro;
  logic [31:0] mem [32];
  int checks = 0, failures = 0;
  logic armed = 1'b0;
  logic [31:0] m_pc, m_ir, m_pa;
  logic m_v, m_par, m_err, m_ini;
  unidade_de_busca #(.ENDERECO_INICIAL(1), .TAM_MEMORIA(TAM)) dut (
    .clock(clock), .reset(reset), .endereco(endereco), .instrucao(instrucao),
    .ir(ir), .ir_valido(ir_valido), .avancar(avancar), .pc_atual(pc_atual),
    .desvio(desvio), .destino(destino), .parado(parado), .erro(erro)
  );
  assign instrucao = endereco < 32 ? mem[endereco[4:0]] : 32'h0;
  always #5 clock = ~clock;
  task automatic chk(input string nome, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nome, act, exp, $time);
    end
  endtask
  always @(posedge clock) begin
    if (reset) begin
      m_pc = 1; m_ir = 0; m_pa = 0; m_v = 0; m_par = 0; m_err = 0; m_ini = 0; armed = 1;
    end else if (m_par) begin
      if (avancar) m_v = 0;
    end else if (desvio) begin
      m_pc = destino; m_v = 0; m_ini = 1;
    end else if (!m_ini) m_ini = 1;
    else if (!m_v || avancar) begin
      if (m_pc < TAM) begin
        m_ir = mem[m_pc[4:0]]; m_pa = m_pc; m_v = 1;
        if (m_ir[31:27] == 5'd18) m_par = 1;
        else m_pc = m_pc + 1;
      end else begin
        m_v = 0; m_err = 1; m_par = 1;
      end
    end
  end
  always @(negedge clock) if (armed) begin
    chk("m_endereco", endereco, m_pc);
    chk("m_ir", ir, m_ir);
    chk("m_ir_valido", 32'(ir_valido), 32'(m_v));
    chk("m_pc_atual", pc_atual, m_pa);
    chk("m_parado", 32'(parado), 32'(m_par));
    chk("m_erro", 32'(erro), 32'(m_err));
  end
  task automatic ciclo(input logic r, input logic a, input logic d, input logic [31:0] t);
    reset = r; avancar = a; desvio = d; destino = t;
    @(negedge clock);
  endtask
  initial begin
    for (int i = 0; i < 32; i++) mem[i] = {5'd1, 27'(i * 3 + 7)};
    mem[6] = HLT_WORD;
    ciclo(1, 1, 0, 0);
    chk("rst_endereco", endereco, 1);
    chk("rst_valido", 32'(ir_valido), 0);
    chk("rst_pc_atual", pc_atual, 0);
    chk("rst_ir", ir, 0);
    chk("rst_parado", 32'(parado), 0);
    ciclo(0, 1, 0, 0);
    chk("espera_valido", 32'(ir_valido), 0);
    ciclo(0, 1, 0, 0);
    chk("first_valido", 32'(ir_valido), 1);
    chk("first_pc_atual", pc_atual, 1);
    for (int i = 2; i <= 6; i++) begin
      ciclo(0, 1, 0, 0);
      chk("seq_pc_atual", pc_atual, 32'(i));
    end
    chk("hlt_parado", 32'(parado), 1);
    chk("hlt_erro", 32'(erro), 0);
    chk("hlt_endereco", endereco, 6);
    chk("hlt_ir", ir, HLT_WORD);
    ciclo(0, 1, 0, 0);
    chk("hlt_consumed", 32'(ir_valido), 0);
    chk("hlt_frozen", endereco, 6);
    ciclo(1, 0, 0, 0);
    ciclo(0, 0, 0, 0);
    ciclo(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      ciclo(0, 0, 0, 0);
      chk("stall_pc_atual", pc_atual, 1);
      chk("stall_endereco", endereco, 2);
      chk("stall_ir", ir, {5'd1, 27'd10});
    end
    ciclo(0, 1, 0, 0);
    chk("resume_pc_atual", pc_atual, 2);
    ciclo(0, 1, 1, 4);
    chk("desvio_bubble", 32'(ir_valido), 0);
    chk("desvio_endereco", endereco, 4);
    ciclo(0, 1, 0, 0);
    chk("desvio_pc_atual", pc_atual, 4);
    chk("desvio_valido", 32'(ir_valido), 1);
    ciclo(0, 1, 1, 25);
    chk("far_endereco", endereco, 25);
    ciclo(0, 1, 0, 0);
    chk("far_erro", 32'(erro), 1);
    chk("far_parado", 32'(parado), 1);
    chk("far_valido", 32'(ir_valido), 0);
    ciclo(0, 1, 1, 3);
    chk("far_ignored", endereco, 25);
    ciclo(1, 1, 0, 0);
    ciclo(0, 1, 0, 0);
    ciclo(0, 1, 0, 0);
    ciclo(0, 1, 0, 0);
    chk("pre_rst_endereco", endereco, 3);
    ciclo(1, 1, 0, 0);
    chk("mid_rst_valido", 32'(ir_valido), 0);
    chk("mid_rst_ir", ir, 0);
    chk("mid_rst_endereco", endereco, 1);
    ciclo(0, 1, 0, 0);
    ciclo(0, 1, 0, 0);
    chk("rerun_pc_atual", pc_atual, 1);
    ciclo(0, 0, 1, 6);
    chk("jmp_hlt_endereco", endereco, 6);
    ciclo(0, 0, 0, 0);
    chk("hold_hlt_parado", 32'(parado), 1);
    chk("hold_hlt_ir", ir, HLT_WORD);
    for (int i = 0; i < 2; i++) begin
      ciclo(0, 0, 0, 0);
      chk("hold_hlt_valido", 32'(ir_valido), 1);
    end
    ciclo(0, 1, 0, 0);
    chk("hold_hlt_drop", 32'(ir_valido), 0);
    ciclo(0, 0, 1, 2);
    chk("parado_desvio", endereco, 6);
    ciclo(1, 1, 0, 0);
    ciclo(0, 1, 0, 0);
    ciclo(0, 1, 1, 20);
    ciclo(0, 1, 0, 0);
    chk("edge_pc_atual", pc_atual, 20);
    chk("edge_erro", 32'(erro), 0);
    ciclo(0, 1, 0, 0);
    chk("edge_fault", 32'(erro), 1);
    chk("edge_valido", 32'(ir_valido), 0);
    ciclo(0, 0, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
